resilient_stage_ctrl: RTL and testbench
=======================================

Name: resilient_stage_ctrl

Overview:
Clocked, parametrised successor to the team's bundled-data error-resilient stage controller. Sequences one pipeline stage through capture, evaluation delay and an error-detection window. Supports ERR_W error-detection lanes and configurable delay and window lengths. On a detected timing error it borrows time, re-latches the stage, then forwards. Sits between two stages on 4-phase req/ack channels and drives the stage's main-latch enable and error-sampling strobe.

Parameters:
ERR_W, 2, number of error-detection lanes (>=1)
DELAY_CYC, 4, evaluation cycles between capture and window open (>=1)
TD_CYC, 2, error-window length and time-borrow (recovery) length in cycles (>=1)
CNT_W, 8, width of saturating error counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous active-low reset
Lreq  in  1  left request (4-phase)
Lack  out  1  left acknowledge
Rreq  out  1  right request (4-phase)
Rack  in  1  right acknowledge
err  in  ERR_W  error-detector flags, one per lane; only meaningful while sample=1
latch_en  out  1  one-cycle main-latch enable pulse
sample  out  1  error-sampling strobe, high across the window
err_flag  out  1  current token was recovered; valid while Rreq=1
err_cnt  out  CNT_W  saturating count of recovered tokens

Behaviour:
- Interface: one clock; reset is synchronous and active-low. Ports are clk and rst.
- Reset (rst=0 at a clock edge): state=IDLE. Lack, Rreq, latch_en, sample, err_flag and err_cnt all 0. Internal counters and the error accumulator are 0. Reset mid-operation aborts the token; no partial outputs persist.
- All outputs are registered. No combinational path from any input to any output.
- States: IDLE, CAPTURE, EVAL, WINDOW, RECOVER, OUT, RTZ.
- IDLE: if Lreq=1 and Lack=0, go to CAPTURE. Otherwise stay.
- CAPTURE (1 cycle): latch_en=1 and Lack set to 1. Go to EVAL with cnt=0.
- EVAL: stay DELAY_CYC cycles, counting cnt 0..DELAY_CYC-1. Then go to WINDOW with cnt=0.
- WINDOW: sample=1 for TD_CYC cycles. Each cycle, acc |= |err.
  - After the last window cycle, go to RECOVER if acc (including that cycle's err) is 1.
  - Otherwise go to OUT with err_flag=0.
- RECOVER: TD_CYC cycles, sample=0. latch_en=1 on the final RECOVER cycle only. On exit: err_flag=1, err_cnt increments (saturates at 2^CNT_W-1), go to OUT.
- OUT: Rreq=1. Wait for Rack=1, then go to RTZ.
- RTZ: Rreq=0. When Rack=0, clear acc and err_flag and go to IDLE.
- Lack is independent of the right side. It is cleared on the first edge where Lack=1 and Lreq=0, in any state. A new capture requires Lack=0, so the left side can return-to-zero while the stage evaluates.
- Ignored inputs:
  - err outside WINDOW.
  - Rack=1 outside OUT/RTZ.
  - Lreq falling before Lack=1 (protocol violation; no state change).
- Latency with no error, Lreq seen high at edge t: latch_en during cycle t+1, sample during t+2+DELAY_CYC .. t+1+DELAY_CYC+TD_CYC, Rreq rises at cycle t+2+DELAY_CYC+TD_CYC. An error adds TD_CYC cycles.
- Simultaneous err on several lanes counts as one recovery. err_cnt never wraps.

Optional Feature:
ERR_LOG_EN.
- Defined: adds input err_clr (1 bit) and output err_log (ERR_W).
  - err_log[i] is sticky. It is set when err[i]=1 during WINDOW.
  - err_clr=1 clears err_log at the next edge. A set in the same cycle as the clear wins.
  - Reset value 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- DELAY_CYC=4, TD_CYC=2, err=0; Lreq rises, seen at edge t -> latch_en pulse cycle t+1, Lack=1 at t+1, sample t+6..t+7, Rreq=1 at t+8, err_flag=0, err_cnt=0.
- Same token with err=2'b01 in cycle t+7 -> RECOVER t+8..t+9, latch_en pulse at t+9, Rreq=1 at t+10 with err_flag=1, err_cnt=1.
- err=2'b11 in cycle t+3 (EVAL) only -> ignored; Rreq at t+8, err_flag=0.
- Rack held 0 for 20 cycles in OUT, Lreq toggles to start a second token -> Lack clears, no second CAPTURE until RTZ→IDLE; second token then completes normally.
- CNT_W=2, five consecutive erroneous tokens -> err_cnt sequence 1,2,3,3,3.
- rst=0 asserted during WINDOW -> next cycle all outputs 0, state IDLE; after rst=1 with Lreq=1, a fresh CAPTURE occurs. With ERR_LOG_EN: err[1] in window -> err_log=2'b10 until err_clr.

Source files
------------

// File: rtl/resilient_stage_ctrl.sv
// Clocked error-resilient pipeline stage controller: capture, evaluate, sample error window,
// optionally borrow TD_CYC cycles to re-latch, then hand off on 4-phase req/ack.
// Optional sticky per-lane error log enabled by defining ERR_LOG_EN.
module resilient_stage_ctrl #(
  parameter int ERR_W     = 2,
  parameter int DELAY_CYC = 4,
  parameter int TD_CYC    = 2,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             Lreq,
  output logic             Lack,
  output logic             Rreq,
  input  logic             Rack,
  input  logic [ERR_W-1:0] err,
  output logic             latch_en,
  output logic             sample,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt
`ifdef ERR_LOG_EN
  ,
  input  logic             err_clr,
  output logic [ERR_W-1:0] err_log
`endif
);

  localparam int MAX_CYC = (DELAY_CYC > TD_CYC) ? DELAY_CYC : TD_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam logic [CW-1:0] EVAL_LAST = CW'(DELAY_CYC - 1);
  localparam logic [CW-1:0] TD_LAST   = CW'(TD_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, CAPTURE, EVAL, WINDOW, RECOVER, OUT, RTZ
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             lack_q, lack_d;
  logic             rreq_q, rreq_d;
  logic             latch_en_q, latch_en_d;
  logic             sample_q, sample_d;
  logic             err_flag_q, err_flag_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    err_flag_d = err_flag_q;
    err_cnt_d  = err_cnt_q;
    // Left ack returns to zero independently of where the token is in the stage.
    lack_d     = (lack_q && !Lreq) ? 1'b0 : lack_q;

    unique case (state_q)
      IDLE: begin
        if (Lreq && !lack_q) begin
          state_d = CAPTURE;
          lack_d  = 1'b1;
        end
      end
      CAPTURE: begin
        state_d = EVAL;
        cnt_d   = '0;
      end
      EVAL: begin
        if (cnt_q == EVAL_LAST) begin
          state_d = WINDOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WINDOW: begin
        acc_d = acc_q | (|err);
        if (cnt_q == TD_LAST) begin
          cnt_d = '0;
          if (acc_d) begin
            state_d = RECOVER;
          end else begin
            state_d    = OUT;
            err_flag_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RECOVER: begin
        if (cnt_q == TD_LAST) begin
          state_d    = OUT;
          cnt_d      = '0;
          err_flag_d = 1'b1;
          if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      OUT: begin
        if (Rack) state_d = RTZ;
      end
      RTZ: begin
        if (!Rack) begin
          state_d    = IDLE;
          acc_d      = 1'b0;
          err_flag_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they appear registered with it.
    latch_en_d = (state_d == CAPTURE) || ((state_d == RECOVER) && (cnt_d == TD_LAST));
    sample_d   = (state_d == WINDOW);
    rreq_d     = (state_d == OUT);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      lack_q     <= 1'b0;
      rreq_q     <= 1'b0;
      latch_en_q <= 1'b0;
      sample_q   <= 1'b0;
      err_flag_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      lack_q     <= lack_d;
      rreq_q     <= rreq_d;
      latch_en_q <= latch_en_d;
      sample_q   <= sample_d;
      err_flag_q <= err_flag_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign Lack     = lack_q;
  assign Rreq     = rreq_q;
  assign latch_en = latch_en_q;
  assign sample   = sample_q;
  assign err_flag = err_flag_q;
  assign err_cnt  = err_cnt_q;

`ifdef ERR_LOG_EN
  logic [ERR_W-1:0] err_log_q, err_log_d;

  // A set in the same cycle as a clear survives the clear.
  always_comb begin
    err_log_d = (err_clr ? '0 : err_log_q) | ((state_q == WINDOW) ? err : '0);
  end

  always_ff @(posedge clk) begin
    if (!rst) err_log_q <= '0;
    else      err_log_q <= err_log_d;
  end

  assign err_log = err_log_q;
`endif

endmodule

// File: tb/tb_resilient_stage_ctrl.sv
// Randomized bench for resilient_stage_ctrl; expectations come from a timeline model that
// derives every output from the cycle offset since capture (define ERR_LOG_EN to cover the log).
module tb_resilient_stage_ctrl;
  localparam int ERR_W     = 2;
  localparam int DELAY_CYC = 4;
  localparam int TD_CYC    = 2;
  localparam int CNT_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;
  localparam int N_CYC     = 4000;

  logic             clk = 1'b0;
  logic             rst;
  logic             Lreq, Lack, Rreq, Rack;
  logic [ERR_W-1:0] err;
  logic             latch_en, sample, err_flag;
  logic [CNT_W-1:0] err_cnt;
`ifdef ERR_LOG_EN
  logic             err_clr;
  logic [ERR_W-1:0] err_log;
`endif

  resilient_stage_ctrl #(
    .ERR_W(ERR_W), .DELAY_CYC(DELAY_CYC), .TD_CYC(TD_CYC), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .Lreq(Lreq), .Lack(Lack), .Rreq(Rreq), .Rack(Rack),
    .err(err), .latch_en(latch_en), .sample(sample), .err_flag(err_flag),
    .err_cnt(err_cnt)
`ifdef ERR_LOG_EN
    , .err_clr(err_clr), .err_log(err_log)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Timeline model: a token captured at edge t0 occupies offsets e = 1.. after that edge.
  bit               m_busy, m_fail, m_rtz, m_lack;
  int               m_t0, m_cnt, m_tokens, m_recov;
  logic [ERR_W-1:0] m_log;

  task automatic model_reset();
    m_busy = 0; m_fail = 0; m_rtz = 0; m_lack = 0;
    m_t0 = 0; m_cnt = 0; m_log = '0;
  endtask

  initial begin
    int  e, out_at;
    bit  x_latch, x_sample, x_rreq, x_flag, cap;
    bit  rst_v, lreq_v, rack_v, clr_v;
    logic [ERR_W-1:0] err_v;

    rst = 1'b0; Lreq = 1'b0; Rack = 1'b0; err = '0;
`ifdef ERR_LOG_EN
    err_clr = 1'b0;
`endif
    m_tokens = 0; m_recov = 0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_lack", Lack, 0);
    check_val("rst_rreq", Rreq, 0);
    check_val("rst_latch", latch_en, 0);
    check_val("rst_sample", sample, 0);
    check_val("rst_flag", err_flag, 0);
    check_val("rst_cnt", err_cnt, 0);
`ifdef ERR_LOG_EN
    check_val("rst_log", err_log, 0);
`endif
    model_reset();
    lreq_v = 0; rack_v = 0;

    for (int unsigned i = 0; i < N_CYC; i++) begin
      e        = cyc + 1 - m_t0;
      out_at   = 2 + DELAY_CYC + TD_CYC + (m_fail ? TD_CYC : 0);
      x_latch  = m_busy && (e == 1 || (m_fail && e == 1 + DELAY_CYC + 2 * TD_CYC));
      x_sample = m_busy && e >= 2 + DELAY_CYC && e <= 1 + DELAY_CYC + TD_CYC;
      x_rreq   = m_busy && e >= out_at && !m_rtz;
      x_flag   = m_busy && m_fail && e >= out_at;

      check_val("lack", Lack, m_lack);
      check_val("rreq", Rreq, x_rreq);
      check_val("latch_en", latch_en, x_latch);
      check_val("sample", sample, x_sample);
      check_val("err_flag", err_flag, x_flag);
      check_val("err_cnt", err_cnt, m_cnt);
`ifdef ERR_LOG_EN
      check_val("err_log", err_log, m_log);
`endif

      rst_v = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 3) == 0) lreq_v = !lreq_v;
      if ($urandom_range(0, 3) == 0) rack_v = !rack_v;
      err_v = ($urandom_range(0, 3) == 0) ? ERR_W'($urandom_range(1, (1 << ERR_W) - 1)) : '0;
      clr_v = ($urandom_range(0, 15) == 0);
      rst = rst_v; Lreq = lreq_v; Rack = rack_v; err = err_v;
`ifdef ERR_LOG_EN
      err_clr = clr_v;
`endif

      if (!rst_v) begin
        model_reset();
      end else begin
        cap = !m_busy && lreq_v && !m_lack;
        if (m_busy) begin
          if (x_sample && err_v != '0) m_fail = 1;
          if (m_fail && e == 1 + DELAY_CYC + 2 * TD_CYC) begin
            m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
            m_recov++;
          end
          if (m_rtz && !rack_v) begin
            m_busy = 0;
            m_tokens++;
          end else if (x_rreq && rack_v) begin
            m_rtz = 1;
          end
        end
        if (cap) m_lack = 1;
        else if (m_lack && !lreq_v) m_lack = 0;
        if (cap) begin
          m_busy = 1; m_t0 = cyc + 1; m_fail = 0; m_rtz = 0;
        end
        m_log = (clr_v ? '0 : m_log) | (x_sample ? err_v : '0);
      end

      @(posedge clk);
      #1;
      cyc++;
    end

    check_val("tokens_done", (m_tokens >= 20) ? 1 : 0, 1);
    check_val("recoveries", (m_recov >= 5) ? 1 : 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
